mem_io_responder: RTL and testbench

- Memory-side responder for the CPU's byte-wide RAM/IO bus (mem_a, mem_wr, mem_dout, mem_din, io_buffer_full).
- Provides 128 KB RAM with 1-cycle read latency.
- Decodes the IO window (addr[17:16]==2'b11): UART byte I/O, a 32-bit cycle counter and the program-stop port.
- Sits between the CPU top and the board UART/HCI logic.

---
 rtl/mem_io_responder.sv | 184 ++++++++++++++++++
 tb/tb_mem_io_responder.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_io_responder.sv
// Byte-wide RAM/IO responder: 128 KB RAM, UART RX/TX with a TX FIFO, a cycle counter and a stop port.
// Optional dropped-byte counter at 0x30008 is enabled by defining RESP_TX_DROP_CNT_EN.
module mem_io_responder #(
  parameter int RAM_ADDR_WIDTH = 17,
  parameter int TX_FIFO_LOG2   = 3,
  parameter int FULL_MARGIN    = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_pop,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        program_end
);

  localparam int DEPTH = 1 << TX_FIFO_LOG2;
  localparam int CW    = TX_FIFO_LOG2 + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH - FULL_MARGIN);

  localparam logic [17:0] ADDR_UART = 18'h30000;
  localparam logic [17:0] ADDR_CNT0 = 18'h30004;
  localparam logic [17:0] ADDR_CNT1 = 18'h30005;
  localparam logic [17:0] ADDR_CNT2 = 18'h30006;
  localparam logic [17:0] ADDR_CNT3 = 18'h30007;
  localparam logic [17:0] ADDR_DROP = 18'h30008;

  logic [17:0] addr;
  logic        io_sel;
  logic        rd_acc;
  logic        wr_acc;
  logic        unused_addr_hi;

  assign addr           = mem_a[17:0];
  assign io_sel         = (addr[17:16] == 2'b11);
  assign rd_acc         = rdy_in && !mem_wr;
  assign wr_acc         = rdy_in && mem_wr;
  assign unused_addr_hi = ^mem_a[31:18];

  // RAM: no reset; writes are gated by rst_in so a reset during an access never lands a byte.
  logic [7:0] ram [2**RAM_ADDR_WIDTH];
  logic [7:0] ram_rd_q;
  logic [RAM_ADDR_WIDTH-1:0] ram_idx;
  logic ram_we;
  logic ram_re;

  assign ram_idx = mem_a[RAM_ADDR_WIDTH-1:0];
  assign ram_we  = wr_acc && !io_sel && rst_in;
  assign ram_re  = rd_acc && !io_sel;

  always_ff @(posedge clk_in) begin
    if (ram_we) ram[ram_idx] <= mem_dout;
    if (ram_re) ram_rd_q <= ram[ram_idx];
  end

  // TX FIFO storage, read asynchronously at the head pointer.
  logic [7:0] fifo_mem [DEPTH];

  logic [31:0]             cnt_q, cnt_d;
  logic [31:0]             snap_q, snap_d;
  logic                    sel_ram_q, sel_ram_d;
  logic [7:0]              io_rd_q, io_rd_d;
  logic                    prog_q, prog_d;
  logic                    full_q, full_d;
  logic [TX_FIFO_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [TX_FIFO_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]           count_q, count_d;
`ifdef RESP_TX_DROP_CNT_EN
  logic [7:0]              drop_q, drop_d;
`endif

  logic       push_req;
  logic       push_ok;
  logic       pop;
  logic [7:0] push_data;
  logic [7:0] io_rd_val;

  always_comb begin
    io_rd_val = 8'h00;
    case (addr)
      ADDR_UART: io_rd_val = rx_valid ? rx_data : 8'h00;
      ADDR_CNT0: io_rd_val = cnt_q[7:0];
      ADDR_CNT1: io_rd_val = snap_q[15:8];
      ADDR_CNT2: io_rd_val = snap_q[23:16];
      ADDR_CNT3: io_rd_val = snap_q[31:24];
`ifdef RESP_TX_DROP_CNT_EN
      ADDR_DROP: io_rd_val = drop_q;
`endif
      default:   io_rd_val = 8'h00;
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q + 32'd1;
    snap_d    = snap_q;
    sel_ram_d = sel_ram_q;
    io_rd_d   = io_rd_q;
    prog_d    = prog_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
`ifdef RESP_TX_DROP_CNT_EN
    drop_d    = drop_q;
`endif

    // Reads select the RAM or IO source for next cycle's mem_din; writes leave it alone.
    if (rd_acc) begin
      sel_ram_d = !io_sel;
      if (io_sel) io_rd_d = io_rd_val;
      if (addr == ADDR_CNT0) snap_d = cnt_q;
    end

    push_req  = wr_acc && (((addr == ADDR_UART) && (mem_dout != 8'h00)) || (addr == ADDR_CNT0));
    push_data = (addr == ADDR_CNT0) ? 8'h00 : mem_dout;
    pop       = (count_q != '0) && tx_ready;
    push_ok   = push_req && ((count_q != DEPTH_C) || pop);

    if (wr_acc && (addr == ADDR_CNT0)) prog_d = 1'b1;

    if (pop) rd_ptr_d = rd_ptr_q + TX_FIFO_LOG2'(1);
    if (push_ok) wr_ptr_d = wr_ptr_q + TX_FIFO_LOG2'(1);
    if (push_ok && !pop) count_d = count_q + CW'(1);
    else if (!push_ok && pop) count_d = count_q - CW'(1);

    full_d = (count_d >= FULL_LVL);

`ifdef RESP_TX_DROP_CNT_EN
    if (wr_acc && (addr == ADDR_DROP)) drop_d = 8'h00;
    else if (push_req && !push_ok && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
`endif
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cnt_q     <= '0;
      snap_q    <= '0;
      sel_ram_q <= 1'b0;
      io_rd_q   <= '0;
      prog_q    <= 1'b0;
      full_q    <= 1'b0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
`ifdef RESP_TX_DROP_CNT_EN
      drop_q    <= '0;
`endif
    end else begin
      cnt_q     <= cnt_d;
      snap_q    <= snap_d;
      sel_ram_q <= sel_ram_d;
      io_rd_q   <= io_rd_d;
      prog_q    <= prog_d;
      full_q    <= full_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
`ifdef RESP_TX_DROP_CNT_EN
      drop_q    <= drop_d;
`endif
    end
  end

  always_ff @(posedge clk_in) begin
    if (push_ok && rst_in) fifo_mem[wr_ptr_q] <= push_data;
  end

  assign mem_din        = sel_ram_q ? ram_rd_q : io_rd_q;
  assign io_buffer_full = full_q;
  assign program_end    = prog_q;
  assign tx_valid       = (count_q != '0);
  assign tx_data        = tx_valid ? fifo_mem[rd_ptr_q] : 8'h00;
  // rx_pop is combinational so the byte is consumed in the access cycle itself.
  assign rx_pop         = rst_in && rd_acc && (addr == ADDR_UART) && rx_valid;

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed plus randomized bench for mem_io_responder against a queue/array reference model.
module tb_mem_io_responder;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b0;
  logic [31:0] mem_a = '0;
  logic        mem_wr = 1'b0;
  logic [7:0]  mem_dout = '0;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_pop;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        program_end;

  mem_io_responder dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .mem_a(mem_a), .mem_wr(mem_wr),
    .mem_dout(mem_dout), .mem_din(mem_din), .io_buffer_full(io_buffer_full),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_pop(rx_pop), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .program_end(program_end)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [7:0]  m_ram [int];
  logic [7:0]  m_q [$];
  logic [7:0]  m_din = 8'h00;
  bit          m_din_known = 1'b1;
  int unsigned m_cnt = 0;
  logic [31:0] m_snap = '0;
  bit          m_prog = 1'b0;
  int unsigned m_drop = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One bus cycle: drive inputs #1 after an edge, check comb outputs, update model, check after edge.
  task automatic step(input logic rdy, input logic [31:0] a, input logic wr, input logic [7:0] d);
    logic [17:0] ad;
    bit          io, popq, push;
    logic [7:0]  val;
    int          size_pre;
    rdy_in = rdy; mem_a = a; mem_wr = wr; mem_dout = d;
    ad = a[17:0];
    io = (ad[17:16] == 2'b11);
    push = 1'b0;
    val = 8'h00;
    #1;
    chk("rx_pop", {31'd0, rx_pop}, {31'd0, rdy && !wr && (ad == 18'h30000) && rx_valid});
    popq = (m_q.size() != 0) && tx_ready;
    if (rdy && !wr) begin
      if (!io) begin
        if (m_ram.exists(int'(ad[16:0]))) begin
          m_din = m_ram[int'(ad[16:0])];
          m_din_known = 1'b1;
        end else begin
          m_din_known = 1'b0;
        end
      end else begin
        m_din_known = 1'b1;
        case (ad)
          18'h30000: m_din = rx_valid ? rx_data : 8'h00;
          18'h30004: begin m_din = m_cnt[7:0]; m_snap = m_cnt; end
          18'h30005: m_din = m_snap[15:8];
          18'h30006: m_din = m_snap[23:16];
          18'h30007: m_din = m_snap[31:24];
`ifdef RESP_TX_DROP_CNT_EN
          18'h30008: m_din = 8'(m_drop);
`endif
          default:   m_din = 8'h00;
        endcase
      end
    end
    if (rdy && wr) begin
      if (!io) m_ram[int'(ad[16:0])] = d;
      else if (ad == 18'h30000 && d != 8'h00) begin push = 1'b1; val = d; end
      else if (ad == 18'h30004) begin push = 1'b1; val = 8'h00; m_prog = 1'b1; end
      else if (ad == 18'h30008) m_drop = 0;
    end
    size_pre = m_q.size();
    if (popq) void'(m_q.pop_front());
    if (push) begin
      if (size_pre < 8 || popq) m_q.push_back(val);
      else if (m_drop < 255) m_drop++;
    end
    m_cnt++;
    @(posedge clk_in);
    #1;
    if (m_din_known) chk("mem_din", {24'd0, mem_din}, {24'd0, m_din});
    chk("tx_valid", {31'd0, tx_valid}, {31'd0, m_q.size() != 0});
    if (m_q.size() != 0) chk("tx_data", {24'd0, tx_data}, {24'd0, m_q[0]});
    chk("io_buffer_full", {31'd0, io_buffer_full}, {31'd0, m_q.size() >= 6});
    chk("program_end", {31'd0, program_end}, {31'd0, m_prog});
  endtask

  task automatic check_reset_outputs();
    chk("rst_mem_din", {24'd0, mem_din}, 32'd0);
    chk("rst_rx_pop", {31'd0, rx_pop}, 32'd0);
    chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("rst_io_full", {31'd0, io_buffer_full}, 32'd0);
    chk("rst_prog_end", {31'd0, program_end}, 32'd0);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear before the next edge.
  task automatic do_reset();
    rst_in = 1'b0;
    #1;
    check_reset_outputs();
    m_q.delete();
    m_din = 8'h00; m_din_known = 1'b1; m_cnt = 0; m_snap = '0; m_prog = 1'b0; m_drop = 0;
    repeat (2) @(posedge clk_in);
    #1;
    rdy_in = 1'b0;
    rst_in = 1'b1;
  endtask

  logic [16:0] ram_pool [5] = '{17'h00010, 17'h00020, 17'h1FFFF, 17'h00000, 17'h0ABCD};
  logic [17:0] io_pool  [7] = '{18'h30000, 18'h30004, 18'h30005, 18'h30006, 18'h30007, 18'h30008, 18'h3FFF0};

  initial begin
    logic [31:0] snap_exp, assembled, a;
    int unsigned r;

    // Reset state
    #1;
    check_reset_outputs();
    repeat (2) @(posedge clk_in);
    #1;
    rst_in = 1'b1;

    // RAM write then read-back on the next cycle
    step(1, 32'h00010, 1, 8'hA5);
    step(1, 32'h00010, 0, 8'h00);
    chk("ram_rdback", {24'd0, mem_din}, 32'hA5);

    // UART receive with and without a valid byte
    rx_valid = 1'b1; rx_data = 8'h41;
    step(1, 32'h30000, 0, 8'h00);
    chk("rx_read", {24'd0, mem_din}, 32'h41);
    rx_valid = 1'b0;
    step(1, 32'h30000, 0, 8'h00);
    chk("rx_empty", {24'd0, mem_din}, 32'h00);

    // Fill the TX FIFO, overflow once, then drain in order
    tx_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step(1, 32'h30000, 1, 8'(i));
      if (i == 5) chk("full_after5", {31'd0, io_buffer_full}, 32'd0);
      if (i == 6) chk("full_after6", {31'd0, io_buffer_full}, 32'd1);
    end
    step(1, 32'h30000, 1, 8'h09);
    chk("tx_count_full", m_q.size(), 32'd8);
`ifdef RESP_TX_DROP_CNT_EN
    step(1, 32'h30008, 0, 8'h00);
    chk("drop_cnt", {24'd0, mem_din}, 32'd1);
`endif
    tx_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk("tx_order", {24'd0, tx_data}, i);
      step(0, 32'h0, 0, 8'h00);
    end
    chk("tx_drained", {31'd0, tx_valid}, 32'd0);

    // Zero filter and stop port
    tx_ready = 1'b0;
    step(1, 32'h30000, 1, 8'h00);
    chk("zero_ignored", {31'd0, tx_valid}, 32'd0);
    step(1, 32'h30004, 1, 8'h77);
    chk("prog_end_set", {31'd0, program_end}, 32'd1);
    chk("stop_byte", {24'd0, tx_data}, 32'h00);
    chk("stop_valid", {31'd0, tx_valid}, 32'd1);
    tx_ready = 1'b1;
    step(0, 32'h0, 0, 8'h00);

    // Coherent counter dword across idle cycles
    snap_exp = m_cnt;
    step(1, 32'h30004, 0, 8'h00);
    assembled[7:0] = mem_din;
    step(0, 32'h0, 0, 8'h00);
    step(1, 32'h30005, 0, 8'h00);
    assembled[15:8] = mem_din;
    step(0, 32'h0, 0, 8'h00);
    step(0, 32'h0, 0, 8'h00);
    step(1, 32'h30006, 0, 8'h00);
    assembled[23:16] = mem_din;
    step(0, 32'h0, 0, 8'h00);
    step(1, 32'h30007, 0, 8'h00);
    assembled[31:24] = mem_din;
    chk("counter_dword", assembled, snap_exp);

    // rdy_in low ignores the write and holds mem_din; upper address bits are ignored
    step(1, 32'h00020, 1, 8'h5A);
    step(1, 32'hFFFC0020, 0, 8'h00);
    chk("ram_hi_bits", {24'd0, mem_din}, 32'h5A);
    rx_valid = 1'b1;
    step(0, 32'h00020, 1, 8'hFF);
    chk("rdy_hold", {24'd0, mem_din}, 32'h5A);
    step(0, 32'h30000, 0, 8'h00);
    step(1, 32'h00020, 0, 8'h00);
    chk("rdy_no_write", {24'd0, mem_din}, 32'h5A);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 11);
      a = $urandom();
      if (r < 5) a[17:0] = {1'b0, ram_pool[r]};
      else a[17:0] = io_pool[r - 5];
      rx_valid = ($urandom_range(0, 1) == 1);
      rx_data  = 8'($urandom());
      tx_ready = ($urandom_range(0, 3) == 0);
      step(($urandom_range(0, 3) != 0), a, ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom()));
    end

    // Mid-stream asynchronous reset with traffic presented and the FIFO loaded
    tx_ready = 1'b0;
    step(1, 32'h30000, 1, 8'h33);
    rx_valid = 1'b1;
    rdy_in = 1'b1; mem_a = 32'h30000; mem_wr = 1'b0;
    do_reset();
    step(1, 32'h00020, 0, 8'h00);
    chk("ram_kept", {24'd0, mem_din}, {24'd0, m_ram[32'h20]});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
